// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the round-robin FP16 adder scheduler:
// operand width, FSM state encoding and a few FP16 constants.
package fp16_pkg;

   localparam int FP16_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
   localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

endpackage

// File: rtl/fpadd_rr_sched_if.sv
// Request/response bundle between NUM_REQ requesters and fpadd_rr_sched.
// Operands and tags are packed per requester, requester i in the i-th slice.
interface fpadd_rr_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4
);
   import fp16_pkg::*;

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*FP16_W-1:0] req_a;
   logic [NUM_REQ*FP16_W-1:0] req_b;
   logic [NUM_REQ*TAG_W-1:0]  req_tag;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [FP16_W-1:0]         rsp_result;
   logic [TAG_W-1:0]          rsp_tag;

   modport master (
      output req_valid, req_a, req_b, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_tag
   );

endinterface

// File: rtl/floatadd.sv
// Combinational FP16 adder: round-to-nearest-even, subnormal inputs and
// outputs, overflow to infinity, Inf/NaN operands passed through.
module floatadd (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   logic [15:0] big, sml;
   logic [4:0]  big_e, sml_e, ediff;
   logic [13:0] big_m, sml_m, sml_sh, mask, norm;
   logic [14:0] acc;
   logic [5:0]  exp_w;
   logic [11:0] mant_r;
   logic        rnd;

   always_comb begin
      big    = (b[14:0] > a[14:0]) ? b : a;
      sml    = (b[14:0] > a[14:0]) ? a : b;
      big_e  = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
      sml_e  = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
      big_m  = {big[14:10] != 5'd0, big[9:0], 3'b000};
      sml_m  = {sml[14:10] != 5'd0, sml[9:0], 3'b000};
      ediff  = big_e - sml_e;
      mask   = (14'd1 << ediff) - 14'd1;
      sml_sh = sml_m >> ediff;
      // Bits shifted out of the smaller operand collapse into a sticky bit.
      sml_sh[0] = sml_sh[0] | (|(sml_m & mask));
      if (big[15] == sml[15]) acc = {1'b0, big_m} + {1'b0, sml_sh};
      else                    acc = {1'b0, big_m} - {1'b0, sml_sh};
      exp_w = {1'b0, big_e};
      if (acc[14]) begin
         norm  = {acc[14:2], acc[1] | acc[0]};
         exp_w = exp_w + 6'd1;
      end else begin
         norm = acc[13:0];
         for (int i = 0; i < 13; i++) begin
            if (!norm[13] && exp_w > 6'd1) begin
               norm  = norm << 1;
               exp_w = exp_w - 6'd1;
            end
         end
      end
      rnd    = norm[2] & (norm[3] | norm[1] | norm[0]);
      mant_r = {1'b0, norm[13:3]} + {11'd0, rnd};
      if (mant_r[11]) begin
         mant_r = mant_r >> 1;
         exp_w  = exp_w + 6'd1;
      end
      if (big[14:10] == 5'h1F)  sum = big;
      else if (acc == 15'd0)    sum = 16'h0000;
      else if (exp_w >= 6'd31)  sum = {big[15], 5'h1F, 10'h000};
      else                      sum = {big[15], mant_r[10] ? exp_w[4:0] : 5'd0, mant_r[9:0]};
   end

endmodule

// File: rtl/fpadd_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module fpadd_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);
   always_comb begin
      any   = 1'b0;
      idx   = '0;
      grant = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int cand;
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = ID_W'(cand);
         end
      end
      if (any) grant = NUM_REQ'(1) << idx;
   end

endmodule

// File: rtl/fpadd_rr_sched.sv
// Round-robin scheduler sharing one floatadd among NUM_REQ requesters.
// Define FPADD_RR_SCHED_STATS_EN to add saturating per-requester grant counters.
module fpadd_rr_sched
   import fp16_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   fpadd_rr_sched_if.slave         bus,
   output logic                    busy
`ifdef FPADD_RR_SCHED_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]   grant_cnt
`endif
);
   localparam int ID_W = $clog2(NUM_REQ);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, op_id_q, op_id_d, rsp_id_q, rsp_id_d;
   logic [FP16_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, rsp_result_q, rsp_result_d, sum;
   logic [TAG_W-1:0]    op_tag_q, op_tag_d, rsp_tag_q, rsp_tag_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ-1:0]  pick_grant;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any, can_grant, take;

   fpadd_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   floatadd u_floatadd (
      .a   (op_a_q),
      .b   (op_b_q),
      .sum (sum)
   );

   // A new grant may overlap the cycle in which the previous response leaves.
   assign can_grant     = (state_q == IDLE) || (state_q == RESP && bus.rsp_ready);
   assign take          = can_grant && pick_any;
   assign bus.req_ready = can_grant ? pick_grant : '0;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_tag_d     = op_tag_q;
      op_id_d      = op_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_id_d     = rsp_id_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = ISSUE;
         ISSUE: begin
            rsp_result_d = sum;
            rsp_tag_d    = op_tag_q;
            rsp_id_d     = op_id_q;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = pick_any ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (take) begin
         op_a_d   = bus.req_a[pick_idx*FP16_W +: FP16_W];
         op_b_d   = bus.req_b[pick_idx*FP16_W +: FP16_W];
         op_tag_d = bus.req_tag[pick_idx*TAG_W +: TAG_W];
         op_id_d  = pick_idx;
         rr_ptr_d = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         op_a_q       <= FP16_ZERO;
         op_b_q       <= FP16_ZERO;
         op_tag_q     <= '0;
         op_id_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= FP16_ZERO;
         rsp_tag_q    <= '0;
         rsp_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_tag_q     <= op_tag_d;
         op_id_q      <= op_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_tag    = rsp_tag_q;
   assign bus.rsp_id     = rsp_id_q;
   assign busy           = (state_q != IDLE);

`ifdef FPADD_RR_SCHED_STATS_EN
   logic [NUM_REQ*16-1:0] grant_cnt_q, grant_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (take && pick_grant[i] && grant_cnt_q[i*16 +: 16] != 16'hFFFF)
            grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) grant_cnt_q <= '0;
      else        grant_cnt_q <= grant_cnt_d;
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fpadd_rr_sched.sv
// Scoreboard bench for fpadd_rr_sched: expected responses are queued at grant
// time and compared as the DUT hands them out on the response bus.
module tb_fpadd_rr_sched;

   localparam int NUM_REQ = 4;
   localparam int TAG_W   = 4;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  tag;
      logic [15:0] sum;
   } op_t;

   typedef struct packed {
      logic [1:0]  id;
      logic [3:0]  tag;
      logic [15:0] sum;
      logic [31:0] gcyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
`ifdef FPADD_RR_SCHED_STATS_EN
   logic [NUM_REQ*16-1:0] grant_cnt;
`endif

   always #5 clk = ~clk;

   fpadd_rr_sched_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

   fpadd_rr_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy)
`ifdef FPADD_RR_SCHED_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   int   assertCount = 0;
   int   failCount   = 0;
   int   cycle       = 0;
   int   grantCount  = 0;
   int   prevGrantCycle = -1;
   bit   rspReady    = 1'b0;
   bit   checkSpacing = 1'b0;
   logic prevRspValid = 1'b0;
   op_t  reqQ[NUM_REQ][$];
   exp_t sbQ[$];
   int   grantOrderQ[$];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   task automatic pushOp(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic [15:0] sum);
      op_t o;
      o.a = a; o.b = b; o.tag = tag; o.sum = sum;
      reqQ[i].push_back(o);
   endtask

   // Present the head of each requester queue; a requester idles when its queue is empty.
   task automatic applyStimulus();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reqQ[i].size() > 0) begin
            bus.req_valid[i]          = 1'b1;
            bus.req_a[i*16 +: 16]     = reqQ[i][0].a;
            bus.req_b[i*16 +: 16]     = reqQ[i][0].b;
            bus.req_tag[i*4 +: 4]     = reqQ[i][0].tag;
         end else begin
            bus.req_valid[i]          = 1'b0;
            bus.req_a[i*16 +: 16]     = 16'h0;
            bus.req_b[i*16 +: 16]     = 16'h0;
            bus.req_tag[i*4 +: 4]     = 4'h0;
         end
      end
      bus.rsp_ready = rspReady;
   endtask

   task automatic sampleOutputs();
      logic [NUM_REQ-1:0] hs;
      exp_t e;
      hs = bus.req_valid & bus.req_ready;
      if (bus.req_ready != '0)
         checkOutput("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs[i]) begin
            e.id   = 2'(i);
            e.tag  = reqQ[i][0].tag;
            e.sum  = reqQ[i][0].sum;
            e.gcyc = 32'(cycle);
            void'(reqQ[i].pop_front());
            sbQ.push_back(e);
            if (grantOrderQ.size() > 0)
               checkOutput("grant_order", 32'(i), 32'(grantOrderQ.pop_front()));
            if (checkSpacing && prevGrantCycle >= 0)
               checkOutput("grant_spacing", 32'(cycle - prevGrantCycle), 32'd2);
            prevGrantCycle = cycle;
            grantCount++;
         end
      end
      if (bus.rsp_valid && !prevRspValid) begin
         if (sbQ.size() == 0) checkOutput("spurious_rsp", 32'd1, 32'd0);
         else checkOutput("latency", 32'(cycle) - sbQ[0].gcyc, 32'd2);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
         if (sbQ.size() == 0) checkOutput("spurious_fire", 32'd1, 32'd0);
         else begin
            e = sbQ.pop_front();
            checkOutput("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            checkOutput("rsp_result", 32'(bus.rsp_result), 32'(e.sum));
            checkOutput("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
         end
      end
      prevRspValid = bus.rsp_valid;
   endtask

   task automatic runCycle();
      @(posedge clk);
      #1;
      cycle++;
      applyStimulus();
      #1;
      sampleOutputs();
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
      sbQ.delete();
      runCycle();
      runCycle();
      rst_n = 1'b1;
      prevGrantCycle = -1;
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         runCycle();
         n++;
         if (reqQ[0].size() == 0 && reqQ[1].size() == 0 && reqQ[2].size() == 0 &&
             reqQ[3].size() == 0 && sbQ.size() == 0 && !busy) break;
      end
      if (n >= budget) checkOutput("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] holdResult;
      logic [3:0]  holdTag;
      logic [1:0]  holdId;
      int          g0, n;

      rst_n = 1'b0;
      applyStimulus();
      doReset();
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      checkOutput("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
      checkOutput("reset_rsp_tag", 32'(bus.rsp_tag), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);

      $display("[TB] single requester 0 and cancellation on requester 2");
      rspReady = 1'b1;
      grantOrderQ = '{0};
      pushOp(0, 16'h3E00, 16'h4100, 4'd3, 16'h4400);
      waitIdle(20);
      grantOrderQ = '{2};
      pushOp(2, 16'hBE00, 16'h3E00, 4'd5, 16'h0000);
      waitIdle(20);

      $display("[TB] all requesters valid after reset");
      doReset();
      rspReady = 1'b1;
      grantOrderQ = '{0, 1, 2, 3};
      checkSpacing = 1'b1;
      pushOp(0, 16'h0000, 16'h4200, 4'd0, 16'h4200);
      pushOp(1, 16'h4580, 16'hC100, 4'd1, 16'h4200);
      pushOp(2, 16'h3E00, 16'h4100, 4'd2, 16'h4400);
      pushOp(3, 16'hBE00, 16'h3E00, 4'd3, 16'h0000);
      waitIdle(40);
      checkSpacing = 1'b0;
      checkOutput("rotation_done", 32'(grantOrderQ.size()), 32'd0);

      $display("[TB] backpressure with requester 1 waiting");
      rspReady = 1'b0;
      pushOp(1, 16'h3E00, 16'h4100, 4'd6, 16'h4400);
      n = 0;
      while (!bus.rsp_valid && n < 10) begin runCycle(); n++; end
      checkOutput("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
      holdResult = bus.rsp_result;
      holdTag    = bus.rsp_tag;
      holdId     = bus.rsp_id;
      pushOp(1, 16'h4580, 16'hC100, 4'd7, 16'h4200);
      for (int k = 0; k < 5; k++) begin
         runCycle();
         checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
         checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         checkOutput("bp_rsp_result", 32'(bus.rsp_result), 32'(holdResult));
         checkOutput("bp_rsp_tag", 32'(bus.rsp_tag), 32'(holdTag));
         checkOutput("bp_rsp_id", 32'(bus.rsp_id), 32'(holdId));
      end
      rspReady = 1'b1;
      runCycle();
      checkOutput("bp_regrant", 32'(bus.req_ready), 32'h2);
      waitIdle(20);

      $display("[TB] reset while an op is in flight");
      pushOp(2, 16'hBE00, 16'h3E00, 4'd8, 16'h0000);
      g0 = grantCount;
      n = 0;
      while (grantCount == g0 && n < 10) begin runCycle(); n++; end
      checkOutput("mid_grant_seen", 32'(grantCount - g0), 32'd1);
      runCycle();
      checkOutput("mid_busy_issue", 32'(busy), 32'd1);
      rst_n = 1'b0;
      sbQ.delete();
      runCycle();
      checkOutput("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("mid_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      prevGrantCycle = -1;
      grantOrderQ = '{0, 3};
      pushOp(0, 16'h3E00, 16'h4100, 4'd1, 16'h4400);
      pushOp(3, 16'h4580, 16'hC100, 4'd2, 16'h4200);
      waitIdle(30);
      checkOutput("post_reset_order", 32'(grantOrderQ.size()), 32'd0);

`ifdef FPADD_RR_SCHED_STATS_EN
      $display("[TB] grant counters");
      doReset();
      rspReady = 1'b1;
      pushOp(1, 16'h3E00, 16'h4100, 4'd1, 16'h4400);
      pushOp(1, 16'h0000, 16'h4200, 4'd2, 16'h4200);
      pushOp(1, 16'hBE00, 16'h3E00, 4'd3, 16'h0000);
      waitIdle(40);
      checkOutput("grant_cnt1", 32'(grant_cnt[31:16]), 32'd3);
      checkOutput("grant_cnt0", 32'(grant_cnt[15:0]), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
